multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 5, opcode width; must be >= 5.
REQ-002 SHALL have parameter ALUOP_W, default 4, ALUop width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, max cycles waiting in MEM; range 1..255.
REQ-004 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- instr_valid  in  1  opcode offered
- opcode  in  OPCODE_W  instruction opcode
- branch_cond  in  1  M-type branch taken
- mem_ready  in  1  data-memory access complete
- stall  in  1  freeze FSM
- instr_ack  out  1  opcode accepted this cycle
- ALUop  out  ALUOP_W  ALU operation
- regWrite, muxWriteReg, muxWriteData, C_reg2_aluB_mux, C_sub_mAluInputB_L, C_mDataMemVsAluOutput, C_L_mux, C_mWwriteDataA, C_offset  out  1 each  datapath selects
- pcSrc  out  1  PC source (1 = branch/jump target)
- pcWrite  out  1  PC update strobe
- C_read_dm, C_write_dm  out  1 each  data-memory strobes
- illegal  out  1  sticky trap flag
- state  out  3  current FSM state
- instr_count  out  CNT_W  retired instructions

Function
REQ-007 SHALL implement states IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6,7 unreachable, recover to IDLE next cycle.
REQ-008 SHALL, in IDLE with instr_valid=1 and stall=0, latch opcode, pulse instr_ack for that cycle, go to DECODE; instr_ack 0 in all other cycles.
REQ-009 SHALL decode latched opcode (low 5 bits): L=00000, I=00001, AR=00010, J=00011, M=00100, P=00111, Q=01000, T=01011, L2=01100.
REQ-010 SHALL, in DECODE, go to TRAP if opcode is unlisted or any bit above bit 4 is nonzero; else go to EXEC.
REQ-011 SHALL, in EXEC: AR/I/T/Q -> WB; L/L2 -> MEM; J/M -> IDLE with pcWrite=1; P -> IDLE.
REQ-012 SHALL drive pcSrc=1 for J and pcSrc=branch_cond (sampled in the EXEC cycle) for M; C_offset=0 for J, 1 for M; pcSrc=0 otherwise.
REQ-013 SHALL, in MEM, hold C_read_dm=1 (L) or C_write_dm=1 (L2) every cycle until mem_ready=1; on mem_ready L -> WB, L2 -> IDLE.
REQ-014 SHALL count MEM cycles; if MEM_TIMEOUT cycles elapse without mem_ready, go to TRAP and drop memory strobes; mem_ready in the MEM_TIMEOUT-th cycle wins over timeout.
REQ-015 SHALL assert regWrite=1 only in WB, exactly one cycle per instruction.
REQ-016 SHALL drive selects from latched opcode in DECODE/EXEC/MEM/WB:
- AR: ALUop all-ones, muxWriteReg 0, muxWriteData 0, C_reg2_aluB_mux 0.
- I: ALUop all-ones, muxWriteReg 1, C_reg2_aluB_mux 1, C_sub_mAluInputB_L 0.
- T: ALUop all-ones, muxWriteReg 1, muxWriteData 1.
- L: ALUop 0, C_reg2_aluB_mux 1, C_sub_mAluInputB_L 1, C_mDataMemVsAluOutput 1, C_L_mux 1.
- L2: ALUop 0, C_reg2_aluB_mux 1, C_sub_mAluInputB_L 1.
- Q: C_L_mux 1, C_mWwriteDataA 1.
- Unlisted selects 0; all selects 0 in IDLE and TRAP.
REQ-017 SHALL, with stall=1 in any state, hold state and MEM counter, force regWrite, pcWrite, instr_ack to 0, and hold other outputs.
REQ-018 SHALL increment instr_count, wrapping modulo 2^CNT_W, on every transition into IDLE from EXEC, MEM or WB.
REQ-019 SHALL, in TRAP, set illegal=1 and remain in TRAP, ignoring all inputs, until RST.

Reset
REQ-020 SHALL on RST=1 at a rising edge, from any state including mid-MEM or TRAP: state IDLE, all outputs 0, instr_count 0, illegal 0, MEM counter 0; RST overrides stall.

Verification
REQ-021 AR opcode 00010, instr_valid one cycle -> instr_ack at cycle 0, states 1,2,4,0, regWrite=1 only in WB, ALUop=1111, instr_count 0->1.
REQ-022 L with mem_ready after 3 MEM cycles -> C_read_dm=1 for 3 cycles, then WB with regWrite=1 and C_mDataMemVsAluOutput=1, 5 states total after accept.
REQ-023 M with branch_cond=1, then M with branch_cond=0 -> pcWrite pulses both times, pcSrc 1 then 0, C_offset=1, regWrite never asserted.
REQ-024 Opcode 00101 (and 100010 when OPCODE_W=6) -> TRAP after DECODE, illegal=1 held 20 cycles despite instr_valid; RST -> IDLE, illegal=0.
REQ-025 L2 with mem_ready held 0 and MEM_TIMEOUT=15 -> C_write_dm=1 for exactly 15 cycles, then TRAP; repeat with mem_ready in cycle 15 -> IDLE.
REQ-026 stall=1 for 4 cycles during WB, then RST asserted mid-MEM -> regWrite low while stalled then one pulse; RST clears all outputs next edge.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake and datapath control bundle between the multicycle sequencer and its core.
// The sequencer connects through the slave modport; the core/fetch side through master.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 16
);
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                branch_cond;
  logic                mem_ready;
  logic                stall;

  logic                instr_ack;
  logic [ALUOP_W-1:0]  ALUop;
  logic                regWrite;
  logic                muxWriteReg;
  logic                muxWriteData;
  logic                C_reg2_aluB_mux;
  logic                C_sub_mAluInputB_L;
  logic                C_mDataMemVsAluOutput;
  logic                C_L_mux;
  logic                C_mWwriteDataA;
  logic                C_offset;
  logic                pcSrc;
  logic                pcWrite;
  logic                C_read_dm;
  logic                C_write_dm;
  logic                illegal;
  logic [2:0]          state;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    output instr_valid, opcode, branch_cond, mem_ready, stall,
    input  instr_ack, ALUop, regWrite, muxWriteReg, muxWriteData, C_reg2_aluB_mux,
           C_sub_mAluInputB_L, C_mDataMemVsAluOutput, C_L_mux, C_mWwriteDataA, C_offset,
           pcSrc, pcWrite, C_read_dm, C_write_dm, illegal, state, instr_count
  );

  modport slave (
    input  instr_valid, opcode, branch_cond, mem_ready, stall,
    output instr_ack, ALUop, regWrite, muxWriteReg, muxWriteData, C_reg2_aluB_mux,
           C_sub_mAluInputB_L, C_mDataMemVsAluOutput, C_L_mux, C_mWwriteDataA, C_offset,
           pcSrc, pcWrite, C_read_dm, C_write_dm, illegal, state, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control sequencer: opcode handshake, decode, execute, memory wait with timeout,
// write-back and a sticky trap state that only RST leaves.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 5,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic                      CLK,
  input logic                      RST,
  multicycle_control_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5,
    BAD6   = 3'd6,
    BAD7   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    K_L   = 4'd0,
    K_I   = 4'd1,
    K_AR  = 4'd2,
    K_J   = 4'd3,
    K_M   = 4'd4,
    K_P   = 4'd5,
    K_Q   = 4'd6,
    K_T   = 4'd7,
    K_L2  = 4'd8,
    K_BAD = 4'd15
  } kind_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluOp;
    logic               regWrite;
    logic               muxWriteReg;
    logic               muxWriteData;
    logic               reg2AluB;
    logic               subAluB;
    logic               memVsAlu;
    logic               lMux;
    logic               wWriteDataA;
    logic               offset;
    logic               pcSrc;
    logic               pcWrite;
    logic               readDm;
    logic               writeDm;
    logic               instrAck;
  } ctrl_t;

  localparam logic [ALUOP_W-1:0] ALU_ONES = {ALUOP_W{1'b1}};
  localparam logic [7:0]         MEM_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Any set bit above the 5-bit opcode field makes the instruction illegal.
  function automatic kind_t decodeKind(input logic [OPCODE_W-1:0] op);
    kind_t k;
    if ((op >> 3'd5) != {OPCODE_W{1'b0}}) begin
      k = K_BAD;
    end else begin
      case (op[4:0])
        5'b00000: k = K_L;
        5'b00001: k = K_I;
        5'b00010: k = K_AR;
        5'b00011: k = K_J;
        5'b00100: k = K_M;
        5'b00111: k = K_P;
        5'b01000: k = K_Q;
        5'b01011: k = K_T;
        5'b01100: k = K_L2;
        default:  k = K_BAD;
      endcase
    end
    return k;
  endfunction

  function automatic ctrl_t selectsFor(input kind_t k);
    ctrl_t c;
    c = '0;
    case (k)
      K_AR: begin
        c.aluOp = ALU_ONES;
      end
      K_I: begin
        c.aluOp       = ALU_ONES;
        c.muxWriteReg = 1'b1;
        c.reg2AluB    = 1'b1;
      end
      K_T: begin
        c.aluOp        = ALU_ONES;
        c.muxWriteReg  = 1'b1;
        c.muxWriteData = 1'b1;
      end
      K_L: begin
        c.reg2AluB = 1'b1;
        c.subAluB  = 1'b1;
        c.memVsAlu = 1'b1;
        c.lMux     = 1'b1;
      end
      K_L2: begin
        c.reg2AluB = 1'b1;
        c.subAluB  = 1'b1;
      end
      K_Q: begin
        c.lMux        = 1'b1;
        c.wWriteDataA = 1'b1;
      end
      K_M: begin
        c.offset = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  state_t              state_r;
  state_t              nextState_s;
  logic [OPCODE_W-1:0] opReg_r;
  logic [7:0]          memCnt_r;
  logic [7:0]          nextCnt_s;
  logic [CNT_W-1:0]    instrCount_r;
  ctrl_t               held_r;
  ctrl_t               ctrl_s;
  kind_t               kind_s;
  logic                latch_s;
  logic                retire_s;

  assign kind_s = decodeKind(opReg_r);

  // Next state, MEM wait count, strobes and selects; a stall replays last cycle's outputs minus pulses.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = memCnt_r;
    latch_s     = 1'b0;
    retire_s    = 1'b0;
    ctrl_s      = '0;
    if (state_r inside {DECODE, EXEC, MEM, WB}) begin
      ctrl_s = selectsFor(kind_s);
    end else begin
      ctrl_s = '0;
    end
    if (bus.stall && (state_r inside {IDLE, DECODE, EXEC, MEM, WB})) begin
      ctrl_s          = held_r;
      ctrl_s.regWrite = 1'b0;
      ctrl_s.pcWrite  = 1'b0;
      ctrl_s.instrAck = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.instr_valid) begin
            ctrl_s.instrAck = ~RST;
            latch_s         = 1'b1;
            nextState_s     = DECODE;
          end else begin
            nextState_s = IDLE;
          end
        end
        DECODE: begin
          nextState_s = (kind_s == K_BAD) ? TRAP : EXEC;
        end
        EXEC: begin
          case (kind_s)
            K_AR, K_I, K_T, K_Q: begin
              nextState_s = WB;
            end
            K_L, K_L2: begin
              nextState_s = MEM;
              nextCnt_s   = 8'd0;
            end
            K_J: begin
              ctrl_s.pcWrite = 1'b1;
              ctrl_s.pcSrc   = 1'b1;
              nextState_s    = IDLE;
              retire_s       = 1'b1;
            end
            K_M: begin
              ctrl_s.pcWrite = 1'b1;
              ctrl_s.pcSrc   = bus.branch_cond;
              nextState_s    = IDLE;
              retire_s       = 1'b1;
            end
            K_P: begin
              nextState_s = IDLE;
              retire_s    = 1'b1;
            end
            default: begin
              nextState_s = TRAP;
            end
          endcase
        end
        MEM: begin
          ctrl_s.readDm  = (kind_s == K_L);
          ctrl_s.writeDm = (kind_s == K_L2);
          // A completion in the last allowed cycle beats the timeout.
          if (bus.mem_ready) begin
            nextCnt_s = 8'd0;
            if (kind_s == K_L) begin
              nextState_s = WB;
            end else begin
              nextState_s = IDLE;
              retire_s    = 1'b1;
            end
          end else if (memCnt_r == MEM_LAST) begin
            nextCnt_s   = 8'd0;
            nextState_s = TRAP;
          end else begin
            nextCnt_s = memCnt_r + 8'd1;
          end
        end
        WB: begin
          ctrl_s.regWrite = 1'b1;
          nextState_s     = IDLE;
          retire_s        = 1'b1;
        end
        TRAP: begin
          nextState_s = TRAP;
        end
        default: begin
          nextState_s = IDLE;
        end
      endcase
    end
  end

  // State, latched opcode, MEM wait counter, retired count and the output snapshot for stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      opReg_r      <= {OPCODE_W{1'b0}};
      memCnt_r     <= 8'd0;
      instrCount_r <= {CNT_W{1'b0}};
      held_r       <= '0;
    end else begin
      state_r  <= nextState_s;
      memCnt_r <= nextCnt_s;
      held_r   <= ctrl_s;
      if (latch_s) begin
        opReg_r <= bus.opcode;
      end else begin
        opReg_r <= opReg_r;
      end
      if (retire_s) begin
        instrCount_r <= instrCount_r + CNT_ONE;
      end else begin
        instrCount_r <= instrCount_r;
      end
    end
  end

  assign bus.instr_ack             = ctrl_s.instrAck;
  assign bus.ALUop                 = ctrl_s.aluOp;
  assign bus.regWrite              = ctrl_s.regWrite;
  assign bus.muxWriteReg           = ctrl_s.muxWriteReg;
  assign bus.muxWriteData          = ctrl_s.muxWriteData;
  assign bus.C_reg2_aluB_mux       = ctrl_s.reg2AluB;
  assign bus.C_sub_mAluInputB_L    = ctrl_s.subAluB;
  assign bus.C_mDataMemVsAluOutput = ctrl_s.memVsAlu;
  assign bus.C_L_mux               = ctrl_s.lMux;
  assign bus.C_mWwriteDataA        = ctrl_s.wWriteDataA;
  assign bus.C_offset              = ctrl_s.offset;
  assign bus.pcSrc                 = ctrl_s.pcSrc;
  assign bus.pcWrite               = ctrl_s.pcWrite;
  assign bus.C_read_dm             = ctrl_s.readDm;
  assign bus.C_write_dm            = ctrl_s.writeDm;
  assign bus.illegal               = (state_r == TRAP);
  assign bus.state                 = state_r;
  assign bus.instr_count           = instrCount_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle compared with a
// reference built from per-opcode tables (select bits, ALU class, path after execute).
module tb_multicycle_control_unit;
  localparam int OPCODE_W    = 6;
  localparam int ALUOP_W     = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checkCnt = 0;
  int   errCnt = 0;

  multicycle_control_unit_if #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(
    .OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Class order: L, I, AR, J, M, P, Q, T, L2. Select bits: {muxWriteReg, muxWriteData,
  // reg2_aluB, sub_aluB_L, dataMemVsAlu, L_mux, wWriteDataA, offset}.
  logic [5:0] legalOps  [9] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h0B, 6'h0C};
  logic [7:0] selTable  [9] = '{8'h3C, 8'hA0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h06, 8'hC0, 8'h30};
  bit         aluOnes   [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int         afterExec [9] = '{3, 4, 4, 0, 0, 0, 4, 4, 3};

  int          mState = 0;
  int          mCnt = 0;
  int          mCount = 0;
  logic [5:0]  mOp = 6'h00;
  logic [17:0] mLast = 18'h0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op);
    if (op[5] != 1'b0) return -1;
    for (int c = 0; c < 9; c++) begin
      if (legalOps[c] == op) return c;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, compare all outputs with the reference, then advance the reference.
  task automatic step(input bit v, input logic [5:0] op, input bit bc, input bit mr,
                      input bit st, input bit rs);
    logic [17:0] e, got;
    logic [3:0]  alu;
    logic [7:0]  sel;
    bit          rw, ps, pw, rd, wr, ack, retire;
    int          cls, nS, nC;
    @(negedge CLK);
    bus.instr_valid = v; bus.opcode = op; bus.branch_cond = bc;
    bus.mem_ready = mr; bus.stall = st; RST = rs;
    #1;
    cls = classify(mOp);
    alu = 4'h0; sel = 8'h00; rw = 1'b0; ps = 1'b0; pw = 1'b0; rd = 1'b0; wr = 1'b0; ack = 1'b0;
    nS = mState; nC = mCnt;
    if (mState >= 1 && mState <= 4 && cls >= 0) begin
      sel = selTable[cls];
      alu = aluOnes[cls] ? 4'hF : 4'h0;
    end
    if (st && mState <= 4) begin
      e = {mLast[17:14], 1'b0, mLast[12:4], 1'b0, mLast[2:1], 1'b0};
    end else begin
      case (mState)
        0: if (v) begin ack = !rs; nS = 1; end
        1: nS = (cls < 0) ? 5 : 2;
        2: begin
          nS = (cls < 0) ? 5 : afterExec[cls];
          nC = 0;
          if (cls == 3) begin pw = 1'b1; ps = 1'b1; end
          if (cls == 4) begin pw = 1'b1; ps = bc; end
        end
        3: begin
          rd = (cls == 0);
          wr = (cls == 8);
          if (mr) nS = (cls == 0) ? 4 : 0;
          else if (mCnt + 1 == MEM_TIMEOUT) nS = 5;
          else nC = mCnt + 1;
        end
        4: begin rw = 1'b1; nS = 0; end
        default: nS = 5;
      endcase
      e = {alu, rw, sel, ps, pw, rd, wr, ack};
    end
    retire = (nS == 0) && (mState >= 2) && (mState <= 4);
    got = {bus.ALUop, bus.regWrite, bus.muxWriteReg, bus.muxWriteData, bus.C_reg2_aluB_mux,
           bus.C_sub_mAluInputB_L, bus.C_mDataMemVsAluOutput, bus.C_L_mux, bus.C_mWwriteDataA,
           bus.C_offset, bus.pcSrc, bus.pcWrite, bus.C_read_dm, bus.C_write_dm, bus.instr_ack};
    checkVal("ctrl", 32'(got), 32'(e));
    checkVal("state", 32'(bus.state), 32'(mState));
    checkVal("illegal", 32'(bus.illegal), 32'(mState == 5));
    checkVal("count", 32'(bus.instr_count), 32'(mCount % (1 << CNT_W)));
    if (rs) begin
      mState = 0; mCnt = 0; mCount = 0; mLast = 18'h0;
    end else begin
      if (mState == 0 && v && !st) mOp = op;
      if (retire) mCount++;
      mState = nS;
      mCnt = nC;
      mLast = e;
    end
  endtask

  task automatic runInstr(input logic [5:0] op, input int readyAt, input bit bc,
                          input int stallWb, input int rstInMem);
    int memN, wbN;
    bit mr, st, rs;
    memN = 0; wbN = 0;
    step(1'b1, op, bc, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 60 && mState != 0 && mState != 5; k++) begin
      mr = 1'b0; st = 1'b0; rs = 1'b0;
      if (mState == 3) begin
        memN++;
        mr = (memN == readyAt);
        rs = (memN == rstInMem);
      end
      if (mState == 4 && wbN < stallWb) begin
        st = 1'b1;
        wbN++;
      end
      step(1'b0, op, bc, mr, st, rs);
    end
  endtask

  task automatic trapHold();
    for (int k = 0; k < 20; k++) step(1'b1, 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    step(1'b1, 6'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int readyPct, trapCycles;
    bit v, st, mr, rs;
    logic [5:0] op;
    bus.instr_valid = 1'b0; bus.opcode = 6'h00; bus.branch_cond = 1'b0;
    bus.mem_ready = 1'b0; bus.stall = 1'b0;
    repeat (2) @(posedge CLK);

    runInstr(6'h02, 0, 1'b0, 0, 0);
    runInstr(6'h00, 3, 1'b0, 0, 0);
    runInstr(6'h04, 0, 1'b1, 0, 0);
    runInstr(6'h04, 0, 1'b0, 0, 0);
    runInstr(6'h03, 0, 1'b0, 0, 0);
    runInstr(6'h01, 0, 1'b0, 4, 0);
    runInstr(6'h00, 99, 1'b0, 0, 2);
    runInstr(6'h0C, 15, 1'b0, 0, 0);
    runInstr(6'h0C, 99, 1'b0, 0, 0);
    trapHold();
    runInstr(6'h05, 0, 1'b0, 0, 0);
    trapHold();
    runInstr(6'h22, 0, 1'b0, 0, 0);
    trapHold();

    readyPct = 45;
    trapCycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mState == 0) readyPct = ($urandom_range(0, 3) == 0) ? 0 : 45;
      if (mState == 5) trapCycles++;
      else trapCycles = 0;
      v  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 99) < readyPct);
      rs = ($urandom_range(0, 399) == 0) || (trapCycles > 25);
      op = ($urandom_range(0, 19) == 0) ? 6'($urandom) : legalOps[$urandom_range(0, 8)];
      step(v, op, 1'($urandom), mr, st, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end
endmodule
